md_ctrl: RTL and testbench

//   Multi-cycle multiply/divide sequencer that sits beside the EX-stage ALU.

---
 rtl/md_ctrl.sv | 126 ++++++++++++
 tb/tb_md_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Models fixed MULT/DIV latencies; busy stalls dependent ops until commit.
module md_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] rs_out,
  input  logic [31:0] rt_out,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W  = 32;
  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          op_p0;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;

  function automatic logic [2*DATA_W-1:0] mul_res(
    input logic              sgn,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] sa;
    logic signed [2*DATA_W-1:0] sb;
    logic signed [2*DATA_W-1:0] sp;
    if (sgn) begin
      sa = {{DATA_W{a[DATA_W-1]}}, a};
      sb = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      sa = {{DATA_W{1'b0}}, a};
      sb = {{DATA_W{1'b0}}, b};
    end
    sp = sa * sb;
    return $unsigned(sp);
  endfunction

  // Returns {remainder, quotient}; signed case divides magnitudes then fixes signs,
  // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  function automatic logic [2*DATA_W-1:0] div_res(
    input logic              sgn,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] ua;
    logic [DATA_W-1:0] ub;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    ua = (sgn && a[DATA_W-1]) ? -a : a;
    ub = (sgn && b[DATA_W-1]) ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sgn && (a[DATA_W-1] ^ b[DATA_W-1])) q = -q;
    if (sgn && a[DATA_W-1]) r = -r;
    return {r, q};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (mdop)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_p0 <= mdop[1:0];
                a_p0  <= rs_out;
                b_p0  <= rt_out;
                cnt   <= mdop[1] ? CNT_W'(DIV_CYC - 1) : CNT_W'(MULT_CYC - 1);
                state <= RUN;
                busy  <= 1'b1;
              end
              3'd4:    hi <= rs_out;
              3'd5:    lo <= rs_out;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == '0) begin
            // commit stage: result from operands latched at issue
            if (!op_p0[1]) begin
              {hi, lo} <= mul_res(~op_p0[0], a_p0, b_p0);
            end else if (b_p0 != '0) begin
              {hi, lo} <= div_res(~op_p0[0], a_p0, b_p0);
            end
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, arithmetic, MTHI/MTLO, cancel and reset.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] rs_out;
  logic [31:0] rt_out;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  md_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdop   (mdop),
    .rs_out (rs_out),
    .rt_out (rt_out),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdop   = op;
    rs_out = a;
    rt_out = b;
    tick();
    start  = 1'b0;
    rs_out = 32'hDEAD_BEEF;
    rt_out = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    tick();
    chk({tag, "_done_pulse_end"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    mdop   = 3'd7;
    rs_out = '0;
    rt_out = '0;
    cancel = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult", 5);
    check_result("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", 5);
    check_result("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 10);
    check_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd3, 32'd7, 32'd0);
    wait_done("divu_zero", 10);
    check_result("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10);
    check_result("div_ovf", 32'h0000_0000, 32'h8000_0000);

    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negb", 10);
    check_result("div_negb", 32'h0000_0001, 32'hFFFF_FFFD);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("divu", 10);
    check_result("divu", 32'h0000_0001, 32'h7FFF_FFFC);

    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_done", {31'b0, done}, 32'd0);
    issue(3'd5, 32'hCAFE_0001, 32'd0);
    chk("mtlo_lo", lo, 32'hCAFE_0001);
    chk("mtlo_hi", hi, 32'h1234_5678);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);

    issue(3'd6, 32'h5555_5555, 32'd1);
    chk("nop_busy", {31'b0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h1234_5678);
    chk("nop_lo", lo, 32'hCAFE_0001);

    issue(3'd0, 32'd3, 32'd4);
    start  = 1'b1;
    mdop   = 3'd1;
    rs_out = 32'd100;
    rt_out = 32'd100;
    tick();
    tick();
    start  = 1'b0;
    wait_done("mult_busy_start", 3);
    check_result("mult_busy_start", 32'd0, 32'd12);
    chk("mult_busy_start_idle", {31'b0, busy}, 32'd0);

    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    chk("cancel_in_run_busy_before", {31'b0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {31'b0, busy}, 32'd0);
    chk("cancel_done", {31'b0, done}, 32'd0);
    chk("cancel_hi", hi, 32'd0);
    chk("cancel_lo", lo, 32'd12);
    for (int i = 0; i < 8; i++) tick();
    chk("cancel_late_done", {31'b0, done}, 32'd0);
    chk("cancel_late_lo", lo, 32'd12);

    cancel = 1'b1;
    issue(3'd0, 32'd9, 32'd9);
    chk("start_cancel_busy", {31'b0, busy}, 32'd0);
    issue(3'd4, 32'h7777_7777, 32'd0);
    cancel = 1'b0;
    chk("mthi_cancel_hi", hi, 32'd0);

    issue(3'd0, 32'd5, 32'd6);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrun_rst_busy", {31'b0, busy}, 32'd0);
    chk("midrun_rst_done", {31'b0, done}, 32'd0);
    chk("midrun_rst_hi", hi, 32'd0);
    chk("midrun_rst_lo", lo, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrun_rst_no_done", {31'b0, done}, 32'd0);
    end

    issue(3'd1, 32'd6, 32'd7);
    wait_done("post_rst_multu", 5);
    check_result("post_rst_multu", 32'd0, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
